// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The result and compare flags go into a single registered response slot.
//
// state | meaning
// EMPTY | response slot holds nothing, rsp_valid=0
// FULL  | response slot holds a result, rsp_valid=1
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_ctrl,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_ctrl,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             rsp_zero,
  output logic             rsp_lt,
  output logic             rsp_ltu,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRA = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state;
  logic        last_grant;
  logic        slot_free;
  logic        gnt0;
  logic        gnt1;
  logic        accept;
  logic        sel;
  logic [2:0]  op_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] op_bm;
  logic [31:0] alu_y;

  assign slot_free = !rsp_valid || rsp_ready;

  // On contention the requester that did not win last time gets the slot.
  assign gnt0 = req0_valid && (!req1_valid || last_grant);
  assign gnt1 = req1_valid && (!req0_valid || !last_grant);

  // Ready is suppressed in a reset cycle so nothing is accepted and then lost.
  assign req0_ready = gnt0 && slot_free && !rst;
  assign req1_ready = gnt1 && slot_free && !rst;
  assign accept     = req0_ready || req1_ready;
  assign sel        = req1_ready;

  assign op_ctrl = sel ? req1_ctrl : req0_ctrl;
  assign op_a    = sel ? req1_a    : req0_a;
  assign op_b    = sel ? req1_b    : req0_b;

  always_comb begin
    op_bm = op_b;
    if (op_ctrl == OP_SLL || op_ctrl == OP_SRA || op_ctrl == OP_SRL)
      op_bm = {27'b0, op_b[4:0]};
  end

  always_comb begin
    alu_y = '0;
    case (op_ctrl)
      OP_ADD:  alu_y = op_a + op_bm;
      OP_SUB:  alu_y = op_a - op_bm;
      OP_AND:  alu_y = op_a & op_bm;
      OP_OR:   alu_y = op_a | op_bm;
      OP_XOR:  alu_y = op_a ^ op_bm;
      OP_SLL:  alu_y = op_a << op_bm[4:0];
      OP_SRA:  alu_y = $unsigned($signed(op_a) >>> op_bm[4:0]);
      OP_SRL:  alu_y = op_a >> op_bm[4:0];
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_lt     <= 1'b0;
      rsp_ltu    <= 1'b0;
      last_grant <= 1'b1;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            rsp_valid <= 1'b1;
          end
        end
        FULL: begin
          if (rsp_ready && !accept) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          rsp_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        rsp_id     <= sel;
        last_grant <= sel;
        rsp_data   <= alu_y;
        // Flags always see the unmasked operand B, whatever the op.
        rsp_zero   <= (op_a == op_b);
        rsp_lt     <= ($signed(op_a) < $signed(op_b));
        rsp_ltu    <= (op_a < op_b);
        if (!sel && cnt0 != '1) cnt0 <= cnt0 + 1'b1;
        if (sel && cnt1 != '1)  cnt1 <= cnt1 + 1'b1;
      end
    end
  end

endmodule
